// File: rtl/next_hop_select.sv
// next_hop_select: scans the neighbour table in shared memory and picks
// the lowest-cost reachable neighbour (not this node) as the next hop.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   start         one-cycle launch pulse (ignored unless idle)
//   iamSink       sink-check result, sampled with start
//   MY_NODE_ID    this node's ID
//   mem_data_out  memory read data, valid one cycle after address
//   address       memory read address (combinational from state/index)
//   next_hop      selected neighbour ID
//   next_hop_cost cost of the selected neighbour
//   valid         next_hop is meaningful
//   busy          scan in progress
//   done          one-cycle completion pulse
module next_hop_select #(
    parameter logic [15:0] NBR_BASE  = 16'h0100,
    parameter int          ADDR_STEP = 2,
    parameter int          MAX_NBR   = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        iamSink,
    input  logic [15:0] MY_NODE_ID,
    input  logic [15:0] mem_data_out,
    output logic [15:0] address,
    output logic [15:0] next_hop,
    output logic [15:0] next_hop_cost,
    output logic        valid,
    output logic        busy,
    output logic        done
);

    localparam int IW = $clog2(MAX_NBR + 1);
    localparam logic [IW-1:0] MAX_N = IW'(MAX_NBR);

    typedef enum logic [2:0] {
        IDLE,
        REQ_CNT,
        LAT_CNT,
        REQ_ID,
        LAT_ID,
        REQ_COST,
        LAT_COST,
        FINISH
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic [IW-1:0] n_cnt;
    logic [IW-1:0] n_clamp;
    logic [15:0]   cand_id;
    logic [15:0]   step;
    logic [15:0]   id_off;
    logic [15:0]   cost_off;
    logic          take;

    assign step     = 16'(ADDR_STEP);
    // Word offset of entry idx's ID is 2*idx+1; its cost follows it.
    assign id_off   = 16'({idx, 1'b1});
    assign cost_off = id_off + 16'd1;
    assign idx_inc  = idx + IW'(1);

    assign n_clamp = (mem_data_out > 16'(MAX_NBR)) ?
                     MAX_N : mem_data_out[IW-1:0];

    // Strict less-than keeps the earlier entry on ties; FFFF marks
    // an unreachable neighbour and our own ID is never a next hop.
    assign take = (mem_data_out < next_hop_cost) &&
                  (mem_data_out != 16'hFFFF) &&
                  (cand_id != MY_NODE_ID);

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    always_comb begin
        address = NBR_BASE;
        unique case (state)
            REQ_ID, LAT_ID:     address = NBR_BASE + step * id_off;
            REQ_COST, LAT_COST: address = NBR_BASE + step * cost_off;
            default:            address = NBR_BASE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= '0;
            n_cnt         <= '0;
            cand_id       <= '0;
            next_hop      <= 16'hFFFF;
            next_hop_cost <= 16'hFFFF;
            valid         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (iamSink) begin
                            next_hop      <= MY_NODE_ID;
                            next_hop_cost <= 16'h0000;
                            valid         <= 1'b1;
                            state         <= FINISH;
                        end else begin
                            next_hop      <= 16'hFFFF;
                            next_hop_cost <= 16'hFFFF;
                            valid         <= 1'b0;
                            state         <= REQ_CNT;
                        end
                    end
                end
                REQ_CNT: state <= LAT_CNT;
                LAT_CNT: begin
                    n_cnt <= n_clamp;
                    idx   <= '0;
                    state <= (n_clamp == '0) ? FINISH : REQ_ID;
                end
                REQ_ID: state <= LAT_ID;
                LAT_ID: begin
                    cand_id <= mem_data_out;
                    state   <= REQ_COST;
                end
                REQ_COST: state <= LAT_COST;
                LAT_COST: begin
                    if (take) begin
                        next_hop      <= cand_id;
                        next_hop_cost <= mem_data_out;
                        valid         <= 1'b1;
                    end
                    idx   <= idx_inc;
                    state <= (idx_inc == n_cnt) ? FINISH : REQ_ID;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_next_hop_select.sv
// tb_next_hop_select: directed checks of next_hop_select against a
// synchronous-read memory model and hand-computed results.
module tb_next_hop_select;

    logic        clock;
    logic        reset;
    logic        start;
    logic        iamSink;
    logic [15:0] MY_NODE_ID;
    logic [15:0] mem_data_out;
    logic [15:0] address;
    logic [15:0] next_hop;
    logic [15:0] next_hop_cost;
    logic        valid;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:65535];

    int nerr;
    int nchk;
    int lat;
    int busy_err;
    logic [15:0] last_addr;
    logic [15:0] max_addr;

    next_hop_select dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .iamSink       (iamSink),
        .MY_NODE_ID    (MY_NODE_ID),
        .mem_data_out  (mem_data_out),
        .address       (address),
        .next_hop      (next_hop),
        .next_hop_cost (next_hop_cost),
        .valid         (valid),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_data_out <= mem[address];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_entry(input int i,
                             input logic [15:0] id,
                             input logic [15:0] cost);
        logic [15:0] a;
        a = 16'h0100 + 16'(2 * (1 + 2 * i));
        mem[a] = id;
        mem[a + 16'd2] = cost;
    endtask

    // Launch with start sampled at edge 0; lat = k where done is seen
    // in the cycle after edge k. extra = k at which a stray start is
    // driven (sampled at edge k+1).
    task automatic run(input logic sink, input int extra);
        lat       = -1;
        busy_err  = 0;
        last_addr = 16'h0100;
        max_addr  = 16'h0100;
        @(negedge clock);
        iamSink = sink;
        start   = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (address != 16'h0100) last_addr = address;
            if (address > max_addr) max_addr = address;
            if (!busy) busy_err++;
            if (done) lat = k;
            start = (k == extra);
            if (lat >= 0) break;
            @(posedge clock);
        end
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("busy_after", busy, 1'b0);
        chk("done_once", done, 1'b0);
    endtask

    task automatic load_normal();
        mem[16'h0100] = 16'd3;
        put_entry(0, 16'd5, 16'd7);
        put_entry(1, 16'd9, 16'd2);
        put_entry(2, 16'd12, 16'd2);
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        reset = 1'b0;
        start = 1'b0;
        iamSink = 1'b0;
        MY_NODE_ID = 16'd3;
        for (int i = 0; i < 512; i++) mem[16'h0100 + 16'(i)] = 16'h0;
        #12;
        chk("rst_hop", next_hop, 16'hFFFF);
        chk("rst_cost", next_hop_cost, 16'hFFFF);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", address, 16'h0100);
        @(negedge clock);
        reset = 1'b1;

        // Normal scan
        load_normal();
        run(1'b0, -1);
        chk("norm_lat", lat, 14);
        chk("norm_hop", next_hop, 16'd9);
        chk("norm_cost", next_hop_cost, 16'd2);
        chk("norm_valid", valid, 1'b1);
        chk("norm_busy", busy_err, 0);
        chk("norm_last", last_addr, 16'h010C);

        // Self and unreachable entries
        mem[16'h0100] = 16'd3;
        put_entry(0, 16'd3, 16'd0);
        put_entry(1, 16'd8, 16'hFFFF);
        put_entry(2, 16'd4, 16'd6);
        run(1'b0, -1);
        chk("self_hop", next_hop, 16'd4);
        chk("self_cost", next_hop_cost, 16'd6);
        chk("self_valid", valid, 1'b1);

        mem[16'h0100] = 16'd2;
        run(1'b0, -1);
        chk("none_lat", lat, 10);
        chk("none_valid", valid, 1'b0);
        chk("none_hop", next_hop, 16'hFFFF);
        chk("none_cost", next_hop_cost, 16'hFFFF);

        // Empty table
        mem[16'h0100] = 16'd0;
        run(1'b0, -1);
        chk("empty_lat", lat, 2);
        chk("empty_valid", valid, 1'b0);

        // Sink short-circuit, plus start in FINISH ignored
        MY_NODE_ID = 16'd17;
        run(1'b1, 0);
        chk("sink_lat", lat, 0);
        chk("sink_hop", next_hop, 16'd17);
        chk("sink_cost", next_hop_cost, 16'd0);
        chk("sink_valid", valid, 1'b1);
        chk("sink_addr", last_addr, 16'h0100);

        // Clamp: count 40 scanned as 32
        MY_NODE_ID = 16'd3;
        mem[16'h0100] = 16'd40;
        for (int i = 0; i < 40; i++)
            put_entry(i, 16'(100 + i), 16'd50);
        put_entry(10, 16'd110, 16'd5);
        put_entry(35, 16'd135, 16'd1);
        run(1'b0, -1);
        chk("clamp_lat", lat, 130);
        chk("clamp_hop", next_hop, 16'd110);
        chk("clamp_cost", next_hop_cost, 16'd5);
        chk("clamp_last", last_addr, 16'h0180);
        chk("clamp_max", max_addr, 16'h0180);

        // Second start mid-scan is ignored
        for (int i = 0; i < 3; i++) put_entry(i, 16'd0, 16'd0);
        load_normal();
        run(1'b0, 5);
        chk("rest_lat", lat, 14);
        chk("rest_hop", next_hop, 16'd9);
        chk("rest_busy", busy_err, 0);

        // Reset during LAT_ID of entry 1
        @(negedge clock);
        iamSink = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            chk("mid_nodone", done, 1'b0);
            @(posedge clock);
        end
        @(negedge clock);
        chk("mid_addr_pre", address, 16'h0106);
        reset = 1'b0;
        #1;
        chk("mid_hop", next_hop, 16'hFFFF);
        chk("mid_cost", next_hop_cost, 16'hFFFF);
        chk("mid_valid", valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_addr", address, 16'h0100);
        @(negedge clock);
        reset = 1'b1;
        run(1'b0, -1);
        chk("post_lat", lat, 14);
        chk("post_hop", next_hop, 16'd9);
        chk("post_cost", next_hop_cost, 16'd2);
        chk("post_valid", valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
